ex_stage_alu_reg: RTL and testbench
===================================

Name: ex_stage_alu_reg

Overview:
- Execute stage directly downstream of the ALU control decoder. Consumes its 4-bit ALU operation code plus ID/EX operands.
- Applies operand forwarding and the ALUSrc mux, computes the result, and registers it with the control bits into the EX/MEM pipeline register.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- DATA_WIDTH, 32, operand/result width
- REG_ADDR_WIDTH, 5, destination register index width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- alu_operation_i  input  4  op code from ALU control
- alu_src_i  input  1  1 = operand B is imm_i, 0 = forwarded rs2
- rs1_data_i  input  DATA_WIDTH  register-file rs1 value
- rs2_data_i  input  DATA_WIDTH  register-file rs2 value
- imm_i  input  DATA_WIDTH  immediate; LUI immediate arrives pre-shifted
- forward_a_i  input  2  rs1 source: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 regfile
- forward_b_i  input  2  rs2 source, same encoding
- ex_mem_fwd_data_i  input  DATA_WIDTH  EX/MEM forwarded value
- mem_wb_fwd_data_i  input  DATA_WIDTH  MEM/WB forwarded value
- rd_i  input  REG_ADDR_WIDTH  destination register
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  input  1 each  control bits
- valid_i  input  1  ID/EX slot holds a real instruction
- stall_i  input  1  hold EX/MEM contents
- flush_i  input  1  insert bubble
- alu_result_o  output  DATA_WIDTH  registered result
- zero_o  output  1  registered (result == 0)
- store_data_o  output  DATA_WIDTH  registered forwarded rs2
- rd_o  output  REG_ADDR_WIDTH  registered rd
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  output  1 each  registered control
- valid_o  output  1  EX/MEM slot valid

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-low and is sampled only on the rising edge.
- Reset values: every output is 0, including valid_o.
- Combinational path:
  - op_a = forward mux(forward_a_i).
  - fwd_b = forward mux(forward_b_i).
  - op_b = alu_src_i ? imm_i : fwd_b.
- Op codes:
  - 0000 ADD: a+b, wraps mod 2^DATA_WIDTH
  - 0001 SUB: a-b, wraps
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLL: a << b[4:0]
  - 0110 SRL: logical a >> b[4:0]; upper bits of b ignored
  - 0111 LUI: result = op_b
  - 1000-1111: result = 0 (zero_o then 1)
- Latency: exactly 1 cycle. Result appears on the clock edge after the inputs are presented. No combinational input-to-output path.
- Register update priority, per rising edge:
  1. reset==0: clear all outputs.
  2. flush_i==1: bubble. valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o = 0; alu_result_o, store_data_o, rd_o = 0; zero_o = 0. Flush overrides a simultaneous stall.
  3. stall_i==1: all outputs hold their previous values.
  4. Otherwise: load the computed values.
- valid_i==0 on a load cycle: load as a bubble. Control bits and valid_o forced to 0; data fields still loaded.
- store_data_o always carries fwd_b, never the immediate, even when alu_src_i==1.
- Reset asserted mid-stall or during a flush: reset wins on that edge.
- After reset deasserts, the first load occurs on the next edge with stall_i==0.

Decomposition:
- Shared package:
  - ALU op code constants (ADD..LUI) matching the ALU control encoding.
  - Forward-select constants (FWD_REG=00, FWD_EX_MEM=01, FWD_MEM_WB=10).
  - DATA_WIDTH default.
- One combinational sub-module `alu_core`: op code + op_a + op_b -> result.
- The top level holds the forwarding muxes, the ALUSrc mux and the EX/MEM register.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> all outputs 0, valid_o=0.
- Ops: a=0x0000000F, b=0x00000003, alu_src=0, valid=1, codes 0000..0111 -> next-cycle results 0x12, 0x0C, 0x03, 0x0F, 0x0C, 0x78, 0x01, 0x03.
- Wrap and zero: SUB 5-5 -> result 0, zero_o=1; ADD 0xFFFFFFFF+1 -> 0, zero_o=1; SLL with b=0x00000021 -> shift by 1.
- Forwarding: rs1_data=1, ex_mem_fwd=0x100, mem_wb_fwd=0x200, rs2_data=2, forward_a=01, forward_b=10, alu_src=1, imm=4, ADD -> result 0x104, store_data_o 0x200.
- Stall/flush: load ADD result 7; stall 3 cycles while inputs change -> outputs hold 7. Then flush and stall asserted together -> valid_o=0, reg_write_o=0, alu_result_o=0.
- Bubble: valid_i=0 with reg_write_i=1, mem_write_i=1 -> next cycle valid_o=0, reg_write_o=0, mem_write_o=0.

Source files
------------

// File: rtl/ex_stage_alu_reg_pkg.sv
// Shared definitions for the execute stage: ALU op codes, forward selects and the default width.
// The op-code encoding must match the upstream ALU control decoder.
package ex_stage_alu_reg_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_LUI = 4'b0111
  } alu_op_e;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;

endpackage

// File: rtl/ex_stage_alu_reg_alu_core.sv
// Purely combinational ALU: op code plus two operands to a result.
// Reserved op codes 1000-1111 produce zero.
module alu_core
  import ex_stage_alu_reg_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  alu_op_e op;
  logic [4:0] shamt;

  assign op    = alu_op_e'(alu_operation_i);
  assign shamt = op_b_i[4:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    result_o = '0;
    case (op)
      ALU_ADD: result_o = op_a_i + op_b_i;
      ALU_SUB: result_o = op_a_i - op_b_i;
      ALU_AND: result_o = op_a_i & op_b_i;
      ALU_OR:  result_o = op_a_i | op_b_i;
      ALU_XOR: result_o = op_a_i ^ op_b_i;
      ALU_SLL: result_o = op_a_i << shamt;
      ALU_SRL: result_o = op_a_i >> shamt;
      ALU_LUI: result_o = op_b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage_alu_reg.sv
// Execute stage: operand forwarding, ALUSrc mux, ALU, and the EX/MEM pipeline register
// with hazard-unit stall (hold) and flush (bubble).
module ex_stage_alu_reg
  import ex_stage_alu_reg_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                alu_operation_i,
  input  logic                      alu_src_i,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic [1:0]                forward_a_i,
  input  logic [1:0]                forward_b_i,
  input  logic [DATA_WIDTH-1:0]     ex_mem_fwd_data_i,
  input  logic [DATA_WIDTH-1:0]     mem_wb_fwd_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_i,
  input  logic                      reg_write_i,
  input  logic                      mem_read_i,
  input  logic                      mem_write_i,
  input  logic                      mem_to_reg_i,
  input  logic                      valid_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic [DATA_WIDTH-1:0]     alu_result_o,
  output logic                      zero_o,
  output logic [DATA_WIDTH-1:0]     store_data_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_o,
  output logic                      reg_write_o,
  output logic                      mem_read_o,
  output logic                      mem_write_o,
  output logic                      mem_to_reg_o,
  output logic                      valid_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     alu_result;
    logic                      zero;
    logic [DATA_WIDTH-1:0]     store_data;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      mem_to_reg;
    logic                      valid;
  } ex_mem_t;

  ex_mem_t ex_mem_d, ex_mem_q;

  logic [DATA_WIDTH-1:0] op_a, fwd_b, op_b, alu_result;

  always_comb begin
    case (forward_a_i)
      FWD_EX_MEM: op_a = ex_mem_fwd_data_i;
      FWD_MEM_WB: op_a = mem_wb_fwd_data_i;
      default:    op_a = rs1_data_i;
    endcase
    case (forward_b_i)
      FWD_EX_MEM: fwd_b = ex_mem_fwd_data_i;
      FWD_MEM_WB: fwd_b = mem_wb_fwd_data_i;
      default:    fwd_b = rs2_data_i;
    endcase
  end

  assign op_b = alu_src_i ? imm_i : fwd_b;

  alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_alu_core (
    .alu_operation_i (alu_operation_i),
    .op_a_i          (op_a),
    .op_b_i          (op_b),
    .result_o        (alu_result)
  );

  // Flush beats stall; an invalid slot still carries its data but none of its control.
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (flush_i) begin
      ex_mem_d = '0;
    end else if (!stall_i) begin
      ex_mem_d.alu_result = alu_result;
      ex_mem_d.zero       = (alu_result == '0);
      ex_mem_d.store_data = fwd_b;
      ex_mem_d.rd         = rd_i;
      ex_mem_d.reg_write  = valid_i & reg_write_i;
      ex_mem_d.mem_read   = valid_i & mem_read_i;
      ex_mem_d.mem_write  = valid_i & mem_write_i;
      ex_mem_d.mem_to_reg = valid_i & mem_to_reg_i;
      ex_mem_d.valid      = valid_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) ex_mem_q <= '0;
    else        ex_mem_q <= ex_mem_d;
  end

  assign alu_result_o = ex_mem_q.alu_result;
  assign zero_o       = ex_mem_q.zero;
  assign store_data_o = ex_mem_q.store_data;
  assign rd_o         = ex_mem_q.rd;
  assign reg_write_o  = ex_mem_q.reg_write;
  assign mem_read_o   = ex_mem_q.mem_read;
  assign mem_write_o  = ex_mem_q.mem_write;
  assign mem_to_reg_o = ex_mem_q.mem_to_reg;
  assign valid_o      = ex_mem_q.valid;

endmodule

// File: tb/tb_ex_stage_alu_reg.sv
// Scoreboard bench for ex_stage_alu_reg: the driver pushes model predictions,
// a negedge monitor pops them and compares against the EX/MEM outputs.
module tb_ex_stage_alu_reg;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    alu_operation_i;
  logic          alu_src_i;
  logic [DW-1:0] rs1_data_i, rs2_data_i, imm_i;
  logic [1:0]    forward_a_i, forward_b_i;
  logic [DW-1:0] ex_mem_fwd_data_i, mem_wb_fwd_data_i;
  logic [RW-1:0] rd_i;
  logic          reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i;
  logic          valid_i, stall_i, flush_i;

  logic [DW-1:0] alu_result_o, store_data_o;
  logic          zero_o;
  logic [RW-1:0] rd_o;
  logic          reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o;

  always #5 clk = ~clk;

  ex_stage_alu_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) dut (
    .clk               (clk),
    .reset             (reset),
    .alu_operation_i   (alu_operation_i),
    .alu_src_i         (alu_src_i),
    .rs1_data_i        (rs1_data_i),
    .rs2_data_i        (rs2_data_i),
    .imm_i             (imm_i),
    .forward_a_i       (forward_a_i),
    .forward_b_i       (forward_b_i),
    .ex_mem_fwd_data_i (ex_mem_fwd_data_i),
    .mem_wb_fwd_data_i (mem_wb_fwd_data_i),
    .rd_i              (rd_i),
    .reg_write_i       (reg_write_i),
    .mem_read_i        (mem_read_i),
    .mem_write_i       (mem_write_i),
    .mem_to_reg_i      (mem_to_reg_i),
    .valid_i           (valid_i),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .alu_result_o      (alu_result_o),
    .zero_o            (zero_o),
    .store_data_o      (store_data_o),
    .rd_o              (rd_o),
    .reg_write_o       (reg_write_o),
    .mem_read_o        (mem_read_o),
    .mem_write_o       (mem_write_o),
    .mem_to_reg_o      (mem_to_reg_o),
    .valid_o           (valid_o)
  );

  typedef struct packed {
    logic [DW-1:0] result;
    logic          zero;
    logic [DW-1:0] store;
    logic [RW-1:0] rd;
    logic          rw, mr, mw, m2r, valid;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  obs_t      model;
  int        checks = 0;
  int        errors = 0;

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got res=%h z=%b st=%h rd=%0d ctl=%b%b%b%b v=%b, want res=%h z=%b st=%h rd=%0d ctl=%b%b%b%b v=%b",
               name, got.result, got.zero, got.store, got.rd, got.rw, got.mr, got.mw, got.m2r, got.valid,
               exp.result, exp.zero, exp.store, exp.rd, exp.rw, exp.mr, exp.mw, exp.m2r, exp.valid);
    end
  endtask

  // Reference ALU written from the op-code table with plain arithmetic.
  function automatic logic [DW-1:0] ref_alu(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint unsigned sh = longint'(b) % 32;
    case (op)
      0: return DW'(longint'(a) + longint'(b));
      1: return DW'(longint'(a) - longint'(b) + 64'h1_0000_0000);
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return DW'(longint'(a) * (64'd1 << sh));
      6: return DW'(longint'(a) / (64'd1 << sh));
      7: return b;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] regval);
    if (sel == 2'd1) return ex_mem_fwd_data_i;
    if (sel == 2'd2) return mem_wb_fwd_data_i;
    return regval;
  endfunction

  // Advance model by the coming edge and queue its prediction.
  task automatic expect_edge(input string name);
    sb_entry_t e;
    logic [DW-1:0] a, fb, b;
    if (!reset || flush_i) begin
      model = '0;
    end else if (!stall_i) begin
      a  = pick(forward_a_i, rs1_data_i);
      fb = pick(forward_b_i, rs2_data_i);
      b  = alu_src_i ? imm_i : fb;
      model.result = ref_alu(int'(alu_operation_i), a, b);
      model.zero   = (model.result == 0);
      model.store  = fb;
      model.rd     = rd_i;
      model.valid  = valid_i;
      model.rw     = valid_i && reg_write_i;
      model.mr     = valid_i && mem_read_i;
      model.mw     = valid_i && mem_write_i;
      model.m2r    = valid_i && mem_to_reg_i;
    end
    e.name = name;
    e.exp  = model;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    alu_operation_i   = 4'($urandom);
    alu_src_i         = 1'($urandom);
    rs1_data_i        = $urandom;
    rs2_data_i        = $urandom;
    imm_i             = $urandom;
    forward_a_i       = 2'($urandom);
    forward_b_i       = 2'($urandom);
    ex_mem_fwd_data_i = $urandom;
    mem_wb_fwd_data_i = $urandom;
    rd_i              = 5'($urandom);
    reg_write_i       = 1'($urandom);
    mem_read_i        = 1'($urandom);
    mem_write_i       = 1'($urandom);
    mem_to_reg_i      = 1'($urandom);
    valid_i           = 1'($urandom);
  endtask

  task automatic set_plain(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    randomize_inputs();
    alu_operation_i = op;
    rs1_data_i      = a;
    rs2_data_i      = b;
    forward_a_i     = 2'b00;
    forward_b_i     = 2'b00;
    alu_src_i       = 1'b0;
    valid_i         = 1'b1;
    stall_i         = 1'b0;
    flush_i         = 1'b0;
    reset           = 1'b1;
  endtask

  // Monitor: each negedge, compare against the oldest pending prediction.
  always @(negedge clk) begin
    sb_entry_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, {alu_result_o, zero_o, store_data_o, rd_o,
                     reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o}, e.exp);
    end
  end

  // Fixed test-plan values checked independently of the reference model.
  task automatic check_const(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  initial begin
    logic [DW-1:0] op_exp [8];
    op_exp = '{32'h12, 32'h0C, 32'h03, 32'h0F, 32'h0C, 32'h78, 32'h01, 32'h03};
    model = '0;

    reset = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    randomize_inputs();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      randomize_inputs();
      stall_i = 1'($urandom);
      flush_i = 1'($urandom);
      expect_edge("reset");
    end

    for (int op = 0; op < 8; op++) begin
      next_cycle();
      set_plain(4'(op), 32'h0000_000F, 32'h0000_0003);
      expect_edge($sformatf("op%0d", op));
      @(posedge clk); #1;
      check_const($sformatf("op%0d_const", op), alu_result_o, op_exp[op]);
    end

    next_cycle(); set_plain(4'd1, 32'd5, 32'd5);                 expect_edge("sub_zero");
    next_cycle(); set_plain(4'd0, 32'hFFFF_FFFF, 32'd1);         expect_edge("add_wrap");
    next_cycle(); set_plain(4'd5, 32'h0000_000F, 32'h0000_0021); expect_edge("sll_b21");
    next_cycle(); set_plain(4'd8, 32'h1234, 32'h5678);           expect_edge("reserved_op");

    next_cycle();
    set_plain(4'd0, 32'd1, 32'd2);
    ex_mem_fwd_data_i = 32'h100; mem_wb_fwd_data_i = 32'h200;
    forward_a_i = 2'b01; forward_b_i = 2'b10; alu_src_i = 1'b1; imm_i = 32'd4;
    expect_edge("forward");
    @(posedge clk); #1;
    check_const("forward_result", alu_result_o, 32'h104);
    check_const("forward_store", store_data_o, 32'h200);

    next_cycle(); set_plain(4'd0, 32'd3, 32'd4); expect_edge("load7");
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      randomize_inputs();
      stall_i = 1'b1;
      expect_edge("stall_hold");
      @(posedge clk); #1;
      check_const("stall_hold_const", alu_result_o, 32'd7);
    end
    next_cycle(); randomize_inputs(); stall_i = 1'b1; flush_i = 1'b1; expect_edge("flush_over_stall");

    next_cycle();
    set_plain(4'd0, 32'd9, 32'd1);
    valid_i = 1'b0; reg_write_i = 1'b1; mem_write_i = 1'b1;
    expect_edge("bubble");

    next_cycle(); set_plain(4'd0, 32'd1, 32'd1); stall_i = 1'b1; reset = 1'b0; expect_edge("reset_in_stall");
    next_cycle(); set_plain(4'd0, 32'd1, 32'd1); stall_i = 1'b1;               expect_edge("stall_after_reset");
    next_cycle(); set_plain(4'd0, 32'd1, 32'd1);                               expect_edge("first_load");

    for (int i = 0; i < 400; i++) begin
      next_cycle();
      randomize_inputs();
      reset   = ($urandom_range(0, 49) != 0);
      stall_i = ($urandom_range(0, 5) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      expect_edge("random");
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
